// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: hold levels, address bus and FSM states.
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int HOLD_W      = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [HOLD_W-1:0]      hold_flag_t;

  localparam inst_addr_t ZERO_WORD = '0;

  localparam hold_flag_t HOLD_NONE = 3'd0;
  localparam hold_flag_t HOLD_PC   = 3'd1;
  localparam hold_flag_t HOLD_IF   = 3'd2;
  localparam hold_flag_t HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Deepest requested stall wins: an ID-level hold also freezes the PC.
  function automatic hold_flag_t hold_level(input logic id_req, input logic pc_req);
    if (id_req)      return HOLD_ID;
    else if (pc_req) return HOLD_PC;
    else             return HOLD_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hold/jump/debug signals between the pipeline sources and the controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       jump_flag_i;
  inst_addr_t jump_addr_i;
  logic       hold_flag_ex_i;
  logic       hold_flag_rib_i;
  logic       hold_flag_clint_i;
  logic       jtag_halt_req_i;
  logic       jtag_halt_ack_o;
  hold_flag_t hold_flag_o;
  logic       jump_flag_o;
  inst_addr_t jump_addr_o;
  logic       timeout_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           hold_flag_clint_i, jtag_halt_req_i,
    input  jtag_halt_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, timeout_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           hold_flag_clint_i, jtag_halt_req_i,
    output jtag_halt_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_hold_timeout_cnt.sv
// Saturating count of consecutive busy cycles; one-cycle pulse on the TIMEOUT_CYCLES-th busy cycle.
module hold_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i)
      cnt_d = '0;
    else if (cnt_q != LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q holds the number of earlier busy cycles, so LAST marks the limit-th one.
  assign timeout_o = busy_i && (cnt_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall sources, sequences jump flushes and debug halts.
// Optional RIB hold timeout is built only when PIPE_CTRL_HOLD_TIMEOUT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 1,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_if.slave     pc_if
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] DRAIN_MAX    = 4'(DRAIN_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       jump_w;
  logic       req_w;
  logic       ack_w;
  logic       id_req_w;
  hold_flag_t hold_w;
  logic       timeout_w;

  assign jump_w = pc_if.jump_flag_i;
  assign req_w  = pc_if.jtag_halt_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (jump_w) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (req_w) begin
          state_d = ST_HALT;
          cnt_d   = 4'd0;
        end
      end
      ST_FLUSH: begin
        if (jump_w) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= 4'd1) begin
          // Leaving the flush is the "return to RUN" where a waiting halt is taken.
          state_d = req_w ? ST_HALT : ST_RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        if (!req_w) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end else if (cnt_q != DRAIN_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_w    = (state_q == ST_HALT) && (cnt_q == DRAIN_MAX) && req_w;
  assign id_req_w = jump_w || (state_q != ST_RUN) || pc_if.hold_flag_ex_i || pc_if.hold_flag_clint_i;
  assign hold_w   = hold_level(id_req_w, pc_if.hold_flag_rib_i);

`ifdef PIPE_CTRL_HOLD_TIMEOUT_EN
  hold_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (pc_if.hold_flag_rib_i),
    .timeout_o(timeout_w)
  );
`else
  // No counter in this build; TIMEOUT_CYCLES is accepted but has no effect.
  assign timeout_w = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Outputs are forced quiet for as long as reset is asserted.
  assign pc_if.hold_flag_o     = rst ? HOLD_NONE : hold_w;
  assign pc_if.jump_flag_o     = rst ? 1'b0      : jump_w;
  assign pc_if.jump_addr_o     = rst ? ZERO_WORD : pc_if.jump_addr_i;
  assign pc_if.jtag_halt_ack_o = rst ? 1'b0      : ack_w;
  assign pc_if.timeout_o       = rst ? 1'b0      : timeout_w;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: three controllers (FLUSH_CYCLES 1, 2, 3; DRAIN_CYCLES 2) driven by shared stimulus.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] addr;
  logic        h_ex, h_rib, h_clint, req;

  logic [2:0]  hold_o [3];
  logic        jf_o   [3];
  logic [31:0] ja_o   [3];
  logic        ack_o  [3];
  logic        to_o   [3];

  int checks = 0;
  int errors = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      pipe_ctrl_if bus ();
      assign bus.jump_flag_i       = jump;
      assign bus.jump_addr_i       = addr;
      assign bus.hold_flag_ex_i    = h_ex;
      assign bus.hold_flag_rib_i   = h_rib;
      assign bus.hold_flag_clint_i = h_clint;
      assign bus.jtag_halt_req_i   = req;
      assign hold_o[gi] = bus.hold_flag_o;
      assign jf_o[gi]   = bus.jump_flag_o;
      assign ja_o[gi]   = bus.jump_addr_o;
      assign ack_o[gi]  = bus.jtag_halt_ack_o;
      assign to_o[gi]   = bus.timeout_o;
      pipe_ctrl #(
        .FLUSH_CYCLES  (gi + 1),
        .DRAIN_CYCLES  (2),
        .TIMEOUT_CYCLES(256)
      ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .pc_if(bus)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump = 0; addr = '0; h_ex = 0; h_rib = 0; h_clint = 0; req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    jump = 1; addr = 32'h0000_1234; h_ex = 1; h_rib = 1; req = 1;
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (hold_o[d] !== 3'd0) begin errors++; $display("FAIL reset_hold dut%0d: got %0d want 0", d, hold_o[d]); end
      checks++;
      if (jf_o[d] !== 1'b0 || ja_o[d] !== 32'h0) begin
        errors++; $display("FAIL reset_jump dut%0d: got flag=%b addr=%h want 0/0", d, jf_o[d], ja_o[d]);
      end
      checks++;
      if (ack_o[d] !== 1'b0 || to_o[d] !== 1'b0) begin
        errors++; $display("FAIL reset_ack_to dut%0d: got ack=%b to=%b want 0/0", d, ack_o[d], to_o[d]);
      end
    end
    $display("reset: outputs checked while rst=1");
    do_reset();
  endtask

  task automatic test_jump_single();
    do_reset();
    jump = 1; addr = 32'h0000_0100;
    #2;
    checks++;
    if (jf_o[0] !== 1'b1 || ja_o[0] !== 32'h0000_0100 || hold_o[0] !== 3'd3) begin
      errors++; $display("FAIL jump1_cycle0: got flag=%b addr=%h hold=%0d want 1/00000100/3", jf_o[0], ja_o[0], hold_o[0]);
    end
    cyc();
    jump = 0;
    #2;
    checks++;
    if (hold_o[0] !== 3'd0 || jf_o[0] !== 1'b0) begin
      errors++; $display("FAIL jump1_cycle1: got hold=%0d flag=%b want 0/0", hold_o[0], jf_o[0]);
    end
    $display("jump FLUSH_CYCLES=1: addr 0x100 forwarded, one hold cycle");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_hold [5];
    exp_hold = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      jump = (c < 2);
      addr = 32'h0000_0400 + 32'(c);
      #2;
      checks++;
      if (hold_o[2] !== exp_hold[c]) begin
        errors++; $display("FAIL b2b_hold cycle%0d: got %0d want %0d", c, hold_o[2], exp_hold[c]);
      end
      cyc();
    end
    jump = 0;
    $display("back-to-back jumps FLUSH_CYCLES=3: hold through cycle 3");
  endtask

  task automatic test_halt();
    logic       exp_ack  [8];
    logic [2:0] exp_hold [8];
    exp_ack  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_hold = '{3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = (c < 6);
      #2;
      checks++;
      if (ack_o[0] !== exp_ack[c] || hold_o[0] !== exp_hold[c]) begin
        errors++; $display("FAIL halt cycle%0d: got ack=%b hold=%0d want %b/%0d", c, ack_o[0], hold_o[0], exp_ack[c], exp_hold[c]);
      end
      cyc();
    end
    $display("halt DRAIN_CYCLES=2: ack cycles 3..5, release at cycle 7");
  endtask

  task automatic test_jump_halt();
    logic exp_ack [6];
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      jump = (c == 0);
      addr = 32'h0000_0200;
      req  = 1;
      #2;
      if (c == 0) begin
        checks++;
        if (jf_o[1] !== 1'b1 || ja_o[1] !== 32'h0000_0200) begin
          errors++; $display("FAIL jh_forward: got flag=%b addr=%h want 1/00000200", jf_o[1], ja_o[1]);
        end
      end
      checks++;
      if (ack_o[1] !== exp_ack[c] || hold_o[1] !== 3'd3) begin
        errors++; $display("FAIL jh cycle%0d: got ack=%b hold=%0d want %b/3", c, ack_o[1], hold_o[1], exp_ack[c]);
      end
      cyc();
    end
    req = 0;
    $display("jump+halt FLUSH_CYCLES=2: ack at cycle 4");
  endtask

  task automatic test_holds();
    logic [2:0] exp_hold [6];
    logic [2:0] vec [6];
    vec      = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b000};
    exp_hold = '{3'd3, 3'd1, 3'd3, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      h_ex = vec[c][2]; h_rib = vec[c][1]; h_clint = vec[c][0];
      #2;
      checks++;
      if (hold_o[0] !== exp_hold[c]) begin
        errors++; $display("FAIL holds ex/rib/clint=%b: got %0d want %0d", vec[c], hold_o[0], exp_hold[c]);
      end
      cyc();
    end
    $display("merged hold sources checked");
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulse_at = -1;
    int bad_hold = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      h_rib = 1;
      #2;
      if (hold_o[0] !== 3'd1) bad_hold++;
      if (to_o[0] === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
      cyc();
    end
    h_rib = 0;
    checks++;
    if (bad_hold !== 0) begin errors++; $display("FAIL timeout_hold: got %0d bad cycles want 0", bad_hold); end
`ifdef PIPE_CTRL_HOLD_TIMEOUT_EN
    checks++;
    if (pulses !== 1 || pulse_at !== 255) begin
      errors++; $display("FAIL timeout_pulse: got %0d pulses first at %0d want 1 at 255", pulses, pulse_at);
    end
`else
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL timeout_off: got %0d pulses want 0", pulses); end
`endif
    $display("rib busy 300 cycles: %0d timeout pulse(s)", pulses);
  endtask

  task automatic test_reset_mid_halt();
    do_reset();
    req = 1;
    for (int c = 0; c < 4; c++) cyc();
    #2;
    checks++;
    if (ack_o[0] !== 1'b1) begin errors++; $display("FAIL mid_halt_ack: got %b want 1", ack_o[0]); end
    rst = 1;
    #1;
    checks++;
    if (ack_o[0] !== 1'b0 || hold_o[0] !== 3'd0) begin
      errors++; $display("FAIL mid_halt_rst: got ack=%b hold=%0d want 0/0", ack_o[0], hold_o[0]);
    end
    cyc();
    req = 0;
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (ack_o[0] !== 1'b0 || hold_o[0] !== 3'd0) begin
        errors++; $display("FAIL post_rst cycle%0d: got ack=%b hold=%0d want 0/0", c, ack_o[0], hold_o[0]);
      end
      cyc();
    end
    req = 1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (ack_o[0] !== (c == 3)) begin
        errors++; $display("FAIL rehalt cycle%0d: got ack=%b want %b", c, ack_o[0], (c == 3));
      end
      cyc();
    end
    req = 0;
    $display("reset mid-HALT: outputs cleared, new halt acked after drain");
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_jump_single();
    test_back_to_back();
    test_halt();
    test_jump_halt();
    test_holds();
    test_timeout();
    test_reset_mid_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
